// File: rtl/spi_flash_arbiter_if.sv
// Pin bundle between the flash arbiter, the MSS SPI_0 fabric signals, the
// fabric SPI master and the flash pads. The arbiter takes the slave modport.
interface spi_flash_arbiter_if;
  // MSS SPI_0 side
  logic       SPI_0_CLK_M2F;
  logic       SPI_0_DO_M2F;
  logic       SPI_0_SS0_M2F;
  logic       SPI_0_SS0_M2F_OE;
  logic       SPI_0_DI_F2M;
  // Fabric master side
  logic       FAB_REQ;
  logic       FAB_GNT;
  logic       FAB_SCK;
  logic       FAB_MOSI;
  logic       FAB_CS_N;
  logic       FAB_MISO;
  // Flash pads
  logic       FLASH_SCK;
  logic       FLASH_MOSI;
  logic       FLASH_CS_N;
  logic       FLASH_MISO;
  // Status
  logic [1:0] OWNER;
  logic       FAB_TIMEOUT;
  logic       MSS_COLLIDE;

  // Handshake: FAB_REQ is a level held by the fabric master for as long as it
  // wants the bus. FAB_GNT=1 means the fabric master owns the pins this cycle
  // and may drive FAB_CS_N low; it hands the bus back by sampling FAB_REQ=0
  // together with FAB_CS_N=1, and FAB_GNT falls after that edge.
  modport slave (
    input  SPI_0_CLK_M2F, SPI_0_DO_M2F, SPI_0_SS0_M2F, SPI_0_SS0_M2F_OE,
    input  FAB_REQ, FAB_SCK, FAB_MOSI, FAB_CS_N, FLASH_MISO,
    output SPI_0_DI_F2M, FAB_GNT, FAB_MISO,
    output FLASH_SCK, FLASH_MOSI, FLASH_CS_N,
    output OWNER, FAB_TIMEOUT, MSS_COLLIDE
  );

  modport master (
    output SPI_0_CLK_M2F, SPI_0_DO_M2F, SPI_0_SS0_M2F, SPI_0_SS0_M2F_OE,
    output FAB_REQ, FAB_SCK, FAB_MOSI, FAB_CS_N, FLASH_MISO,
    input  SPI_0_DI_F2M, FAB_GNT, FAB_MISO,
    input  FLASH_SCK, FLASH_MOSI, FLASH_CS_N,
    input  OWNER, FAB_TIMEOUT, MSS_COLLIDE
  );
endinterface

// File: rtl/spi_flash_arbiter.sv
// Shares the SPI flash pins between MSS SPI_0 (default owner) and a fabric master.
// Optional hold timeout with forced release is built when SPI_ARB_TIMEOUT_EN is defined.
module spi_flash_arbiter #(
  parameter int GUARD_CYCLES = 4,
  parameter int HOLD_TIMEOUT = 65535
) (
  input logic                CLK_BASE,
  input logic                FAB_RESET,
  spi_flash_arbiter_if.slave bus
);
  localparam int GW = $clog2(GUARD_CYCLES + 1);

  localparam logic [1:0] MSS_OWN = 2'b00;
  localparam logic [1:0] GUARD   = 2'b01;
  localparam logic [1:0] FAB_OWN = 2'b10;
  localparam logic [1:0] RELEASE = 2'b11;

  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES);
  localparam logic [GW-1:0] REL_LAST   = GW'(GUARD_CYCLES - 1);

  logic [1:0]    state, state_nx;
  logic [GW-1:0] guard_cnt, guard_cnt_nx;
  logic          gnt_q, collide_q, mss_active_q;
  logic          mss_active, fab_done, hold_done, armed;

  assign mss_active = bus.SPI_0_SS0_M2F_OE & ~bus.SPI_0_SS0_M2F;
  assign fab_done   = ~bus.FAB_REQ & bus.FAB_CS_N;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int HW = $clog2(HOLD_TIMEOUT);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TIMEOUT - 1);

  logic [HW-1:0] hold_cnt;
  logic          armed_q, timeout_q, forced;

  assign hold_done = (state == FAB_OWN) && (hold_cnt == HOLD_LAST);
  // A request already dropped on the timeout cycle counts as a normal release.
  assign forced    = hold_done & bus.FAB_REQ;

  always_ff @(posedge CLK_BASE) begin
    if (FAB_RESET) begin
      hold_cnt  <= '0;
      armed_q   <= 1'b1;
      timeout_q <= 1'b0;
    end else begin
      if (state == FAB_OWN && state_nx == FAB_OWN) hold_cnt <= hold_cnt + 1'b1;
      else                                         hold_cnt <= '0;
      if (forced)            armed_q <= 1'b0;
      else if (!bus.FAB_REQ) armed_q <= 1'b1;
      timeout_q <= forced;
    end
  end

  assign armed           = armed_q;
  assign bus.FAB_TIMEOUT = timeout_q;
`else
  assign hold_done       = 1'b0;
  assign armed           = 1'b1;
  assign bus.FAB_TIMEOUT = 1'b0;
`endif

  // The guard counter is zero on every state entry; GUARD and RELEASE count up from it.
  always_comb begin
    state_nx     = state;
    guard_cnt_nx = '0;
    case (state)
      MSS_OWN: begin
        if (bus.FAB_REQ && !mss_active && armed) state_nx = GUARD;
      end
      GUARD: begin
        if (mss_active || !bus.FAB_REQ)  state_nx = MSS_OWN;
        else if (guard_cnt == GUARD_LAST) state_nx = FAB_OWN;
        else                              guard_cnt_nx = guard_cnt + 1'b1;
      end
      FAB_OWN: begin
        if (fab_done || hold_done) state_nx = RELEASE;
      end
      default: begin
        if (guard_cnt == REL_LAST) state_nx = MSS_OWN;
        else                       guard_cnt_nx = guard_cnt + 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK_BASE) begin
    if (FAB_RESET) begin
      state        <= MSS_OWN;
      guard_cnt    <= '0;
      gnt_q        <= 1'b0;
      collide_q    <= 1'b0;
      mss_active_q <= 1'b0;
    end else begin
      state        <= state_nx;
      guard_cnt    <= guard_cnt_nx;
      gnt_q        <= (state_nx == FAB_OWN);
      mss_active_q <= mss_active;
      // state[1] covers FAB_OWN and RELEASE, where the MSS is locked out.
      collide_q    <= mss_active & ~mss_active_q & state[1];
    end
  end

  assign bus.OWNER       = state;
  assign bus.FAB_GNT     = gnt_q;
  assign bus.MSS_COLLIDE = collide_q;

  always_comb begin
    bus.FLASH_CS_N   = 1'b1;
    bus.FLASH_SCK    = 1'b0;
    bus.FLASH_MOSI   = 1'b0;
    bus.SPI_0_DI_F2M = 1'b1;
    bus.FAB_MISO     = 1'b0;
    case (state)
      MSS_OWN, GUARD: begin
        bus.FLASH_CS_N   = bus.SPI_0_SS0_M2F_OE ? bus.SPI_0_SS0_M2F : 1'b1;
        bus.FLASH_SCK    = bus.SPI_0_CLK_M2F;
        bus.FLASH_MOSI   = bus.SPI_0_DO_M2F;
        bus.SPI_0_DI_F2M = bus.FLASH_MISO;
      end
      FAB_OWN: begin
        bus.FLASH_CS_N = bus.FAB_CS_N;
        bus.FLASH_SCK  = bus.FAB_SCK;
        bus.FLASH_MOSI = bus.FAB_MOSI;
        bus.FAB_MISO   = bus.FLASH_MISO;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Directed bench for spi_flash_arbiter: per-cycle expected pin/status vectors
// are queued by the stimulus and checked by a negedge monitor.
module tb_spi_flash_arbiter;
  localparam int W = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic oe, ss, mclk, mdo, req, fcs, fsck, fmosi, miso;

  spi_flash_arbiter_if bus ();
  assign bus.SPI_0_SS0_M2F_OE = oe;
  assign bus.SPI_0_SS0_M2F    = ss;
  assign bus.SPI_0_CLK_M2F    = mclk;
  assign bus.SPI_0_DO_M2F     = mdo;
  assign bus.FAB_REQ          = req;
  assign bus.FAB_CS_N         = fcs;
  assign bus.FAB_SCK          = fsck;
  assign bus.FAB_MOSI         = fmosi;
  assign bus.FLASH_MISO       = miso;

  spi_flash_arbiter #(.GUARD_CYCLES(4), .HOLD_TIMEOUT(16)) dut (
    .CLK_BASE  (clk),
    .FAB_RESET (rst),
    .bus       (bus)
  );

  // {OWNER, GNT, TIMEOUT, COLLIDE, FLASH_CS_N, FLASH_SCK, FLASH_MOSI, DI_F2M, FAB_MISO}
  logic [W-1:0] obs;
  assign obs = {bus.OWNER, bus.FAB_GNT, bus.FAB_TIMEOUT, bus.MSS_COLLIDE,
                bus.FLASH_CS_N, bus.FLASH_SCK, bus.FLASH_MOSI,
                bus.SPI_0_DI_F2M, bus.FAB_MISO};

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] mon_exp;
  string        mon_name;

  function automatic logic [W-1:0] ev(input logic [1:0] own, input logic gnt, to, col,
                                      cs, sck, mosi, di, fm);
    return {own, gnt, to, col, cs, sck, mosi, di, fm};
  endfunction

  task automatic drv(input logic i_oe, i_ss, i_mclk, i_mdo, i_req, i_fcs, i_fsck,
                     i_fmosi, i_miso);
    oe = i_oe; ss = i_ss; mclk = i_mclk; mdo = i_mdo; req = i_req;
    fcs = i_fcs; fsck = i_fsck; fmosi = i_fmosi; miso = i_miso;
  endtask

  // Queue the expectation for this cycle's negedge, then advance one cycle.
  task automatic tick(input string nm, input logic [W-1:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      checks++;
      if (obs !== mon_exp) begin
        errors++;
        $display("FAIL %s: got %b expected %b (own gnt to col cs sck mosi di fm)",
                 mon_name, obs, mon_exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drv(0, 1, 1, 1, 0, 1, 0, 0, 1);
    @(posedge clk); #1;
    tick("reset_state", ev(0, 0, 0, 0, 1, 1, 1, 1, 0));
    rst = 1'b0;

    // MSS transfers pass straight through while it owns the bus.
    drv(1, 0, 0, 1, 0, 1, 0, 0, 0); tick("mss_xfer_a", ev(0, 0, 0, 0, 0, 0, 1, 0, 0));
    drv(1, 0, 1, 0, 0, 1, 0, 0, 1); tick("mss_xfer_b", ev(0, 0, 0, 0, 0, 1, 0, 1, 0));
    drv(0, 0, 0, 0, 0, 1, 0, 0, 0); tick("mss_oe_low", ev(0, 0, 0, 0, 1, 0, 0, 0, 0));

    // Grant: REQ sampled at edge 0, GNT after edge 5.
    drv(0, 1, 1, 1, 1, 1, 0, 0, 1); tick("req_edge0", ev(0, 0, 0, 0, 1, 1, 1, 1, 0));
    for (int i = 0; i < 5; i++) tick("guard_wait", ev(1, 0, 0, 0, 1, 1, 1, 1, 0));
    tick("grant", ev(2, 1, 0, 0, 1, 0, 0, 1, 1));
    drv(0, 1, 1, 1, 1, 0, 1, 1, 0); tick("fab_path_a", ev(2, 1, 0, 0, 0, 1, 1, 1, 0));
    drv(0, 1, 1, 1, 1, 0, 0, 0, 1); tick("fab_path_b", ev(2, 1, 0, 0, 0, 0, 0, 1, 1));

    // MSS asserts CS during FAB_OWN: one collide pulse, pins stay on the fabric.
    drv(1, 0, 0, 0, 1, 0, 1, 1, 0); tick("collide_pre",   ev(2, 1, 0, 0, 0, 1, 1, 1, 0));
    tick("collide_pulse", ev(2, 1, 0, 1, 0, 1, 1, 1, 0));
    tick("collide_once",  ev(2, 1, 0, 0, 0, 1, 1, 1, 0));

    // Normal release at edge n, MSS collides inside RELEASE, MSS path back after n+4.
    drv(0, 1, 1, 1, 0, 1, 0, 0, 1); tick("rel_edge_n", ev(2, 1, 0, 0, 1, 0, 0, 1, 1));
    tick("release_0", ev(3, 0, 0, 0, 1, 0, 0, 1, 0));
    drv(1, 0, 1, 1, 0, 1, 0, 0, 1); tick("release_1",   ev(3, 0, 0, 0, 1, 0, 0, 1, 0));
    tick("release_col", ev(3, 0, 0, 1, 1, 0, 0, 1, 0));
    tick("release_3",   ev(3, 0, 0, 0, 1, 0, 0, 1, 0));
    tick("mss_restored", ev(0, 0, 0, 0, 0, 1, 1, 1, 0));

    // REQ while MSS busy: no guard until MSS CS rises.
    drv(1, 0, 0, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick("req_mss_busy", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
    drv(0, 1, 0, 0, 1, 1, 0, 0, 0); tick("guard_start", ev(0, 0, 0, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) tick("guard_cnt", ev(1, 0, 0, 0, 1, 0, 0, 0, 0));
    // MSS re-asserts at guard count 3.
    drv(1, 0, 0, 0, 1, 1, 0, 0, 0); tick("guard_mss_back", ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
    drv(0, 1, 0, 0, 1, 1, 0, 0, 0); tick("guard_abort", ev(0, 0, 0, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) tick("guard_retry", ev(1, 0, 0, 0, 1, 0, 0, 0, 0));
    // MSS active on the cycle the guard completes: MSS wins.
    drv(1, 0, 0, 0, 1, 1, 0, 0, 0); tick("guard_last_mss", ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
    drv(0, 1, 0, 0, 1, 1, 0, 0, 0); tick("guard_tie_mss", ev(0, 0, 0, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) tick("guard_clean", ev(1, 0, 0, 0, 1, 0, 0, 0, 0));
    tick("regrant", ev(2, 1, 0, 0, 1, 0, 0, 1, 0));

    // Reset mid FAB_OWN truncates the transfer with no RELEASE guard.
    rst = 1'b1;
    drv(0, 1, 0, 0, 1, 0, 1, 0, 1); tick("fab_busy_rst", ev(2, 1, 0, 0, 0, 1, 0, 1, 1));
    rst = 1'b0;
    drv(0, 1, 0, 0, 0, 1, 0, 0, 1); tick("after_reset", ev(0, 0, 0, 0, 1, 0, 0, 1, 0));

    drv(0, 1, 0, 0, 1, 1, 0, 0, 0); tick("hold_req", ev(0, 0, 0, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) tick("hold_guard", ev(1, 0, 0, 0, 1, 0, 0, 0, 0));
`ifdef SPI_ARB_TIMEOUT_EN
    // Forced release after exactly 16 owned cycles, then disarmed until REQ drops.
    for (int i = 0; i < 16; i++) tick("to_hold", ev(2, 1, 0, 0, 1, 0, 0, 1, 0));
    tick("to_pulse", ev(3, 0, 1, 0, 1, 0, 0, 1, 0));
    for (int i = 0; i < 3; i++) tick("to_release", ev(3, 0, 0, 0, 1, 0, 0, 1, 0));
    for (int i = 0; i < 3; i++) tick("to_disarmed", ev(0, 0, 0, 0, 1, 0, 0, 0, 0));
    drv(0, 1, 0, 0, 0, 1, 0, 0, 0); tick("to_rearm",  ev(0, 0, 0, 0, 1, 0, 0, 0, 0));
    drv(0, 1, 0, 0, 1, 1, 0, 0, 0); tick("to_rereq",  ev(0, 0, 0, 0, 1, 0, 0, 0, 0));
    tick("to_reguard", ev(1, 0, 0, 0, 1, 0, 0, 0, 0));
    drv(0, 1, 0, 0, 0, 1, 0, 0, 0); tick("to_drop",   ev(1, 0, 0, 0, 1, 0, 0, 0, 0));
    tick("to_idle", ev(0, 0, 0, 0, 1, 0, 0, 0, 0));
`else
    // Without the timeout the fabric keeps the bus until it releases.
    for (int i = 0; i < 20; i++) tick("nl_hold", ev(2, 1, 0, 0, 1, 0, 0, 1, 0));
    drv(0, 1, 0, 0, 0, 1, 0, 0, 0); tick("nl_rel_n", ev(2, 1, 0, 0, 1, 0, 0, 1, 0));
    for (int i = 0; i < 4; i++) tick("nl_release", ev(3, 0, 0, 0, 1, 0, 0, 1, 0));
    tick("nl_mss", ev(0, 0, 0, 0, 1, 0, 0, 0, 0));
`endif

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
